// File: rtl/reg_demux32_bank_pkg.sv
// reg_demux32_bank_pkg: shared sizing constants for the register bank write side.
package reg_demux32_bank_pkg;
  localparam int WORD_LENGTH = 32;
  localparam int REG_COUNT   = 32;
  localparam int REG_SEL_W   = 5;
endpackage

// File: rtl/reg_demux32_bank_decoder5to32.sv
// reg_demux32_bank_decoder5to32: 5-bit select plus enable to 32-bit one-hot.
module reg_demux32_bank_decoder5to32
  import reg_demux32_bank_pkg::*;
(
  input  logic [REG_SEL_W-1:0] sel,
  input  logic                 en,
  output logic [REG_COUNT-1:0] onehot
);
  assign onehot = en ? REG_COUNT'(1) << sel : '0;
endmodule

// File: rtl/reg_demux32_bank.sv
// reg_demux32_bank: 32-entry register array write side with a per-register busy scoreboard.
module reg_demux32_bank
  import reg_demux32_bank_pkg::*;
#(
  parameter int n        = WORD_LENGTH,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [REG_SEL_W-1:0] wr_sel,
  input  logic [n-1:0]         wr_data,
  input  logic                 rsv_valid,
  input  logic [REG_SEL_W-1:0] rsv_sel,
  output logic [n-1:0]         regs [REG_COUNT-1:0],
  output logic [REG_COUNT-1:0] busy
);
  logic [REG_COUNT-1:0][n-1:0] q;
  logic [REG_COUNT-1:0]        we_raw, set_raw, we, set, keep;
  reg_demux32_bank_decoder5to32 u_wr_dec (.sel(wr_sel), .en(wr_valid && wr_ready), .onehot(we_raw));
  reg_demux32_bank_decoder5to32 u_rsv_dec (.sel(rsv_sel), .en(rsv_valid), .onehot(set_raw));
  // With a hardwired zero register, entry 0 is never written or reserved, so it stays at its reset value.
  assign keep = ZERO_REG ? ~REG_COUNT'(1) : '1;
  assign we   = we_raw & keep;
  assign set  = set_raw & keep;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q        <= '0;
      busy     <= '0;
      wr_ready <= 1'b0;
    end else begin
      wr_ready <= 1'b1;
      busy     <= (busy & ~we) | set;
      for (int i = 0; i < REG_COUNT; i++)
        if (we[i]) q[i] <= wr_data;
    end
  always_comb
    for (int i = 0; i < REG_COUNT; i++) regs[i] = q[i];
endmodule
